uart_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller that lets the Riscv151 datapath share the on-chip UART and two performance counters through ordinary load/store accesses in the 0x8000_00xx window. It sits between the CPU memory stage and the uart instance and sequences both UART ready/valid handshakes. It buffers received bytes and holds one outgoing byte until the transmitter accepts it. Read data is registered, so its timing matches the synchronous BRAMs.

---
 rtl/uart_mmio_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// uart_mmio_ctrl
//
// Memory-mapped bridge between the Riscv151 memory stage and the UART. It
// exposes UART status, RX/TX data and two 32-bit performance counters in a
// 256-byte window at MMIO_BASE. Load data is registered, so it lines up with
// the synchronous BRAM read timing.
//
// Register map (offset from MMIO_BASE):
//   0x00 status    RO  bit0 = tx_free, bit1 = rx_avail
//   0x04 rx_data   RO  returns and pops the head RX byte (0 if empty)
//   0x08 tx_data   WO  byte to transmit; dropped while the TX slot is busy
//   0x10 cycle_cnt RO  free-running cycle counter
//   0x14 inst_cnt  RO  retired-instruction counter
//   0x18 cnt_reset WO  any store clears both counters
//
// Build option:
//   UART_RX_FIFO_EN  defined   -> RX buffer is a RX_FIFO_DEPTH-entry FIFO
//                    undefined -> RX buffer is a single byte plus valid flag
//
// Ports:
//   clk, rst                  core clock, asynchronous active-low reset
//   cpu_addr/wdata/we/re      CPU load/store request
//   cpu_rdata                 load data, valid the cycle after cpu_re
//   inst_retired              one pulse per retired instruction
//   uart_tx_data/valid/ready  handshake towards the UART transmitter
//   uart_rx_data/valid/ready  handshake from the UART receiver
// -----------------------------------------------------------------------------
module uart_mmio_ctrl #(
    parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
    parameter int          RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [7:0] OFF_STATUS    = 8'h00;
    localparam logic [7:0] OFF_RX_DATA   = 8'h04;
    localparam logic [7:0] OFF_TX_DATA   = 8'h08;
    localparam logic [7:0] OFF_CYCLE_CNT = 8'h10;
    localparam logic [7:0] OFF_INST_CNT  = 8'h14;
    localparam logic [7:0] OFF_CNT_RESET = 8'h18;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic       win_hit;
    logic [7:0] offset;
    logic       store;
    logic       load;

    assign win_hit = (cpu_addr[31:8] == MMIO_BASE[31:8]);
    assign offset  = cpu_addr[7:0];
    assign store   = win_hit && (|cpu_we);
    assign load    = win_hit && cpu_re;

    logic tx_store;
    logic cnt_clear;
    logic rx_pop_req;

    assign tx_store   = store && (offset == OFF_TX_DATA);
    assign cnt_clear  = store && (offset == OFF_CNT_RESET);
    assign rx_pop_req = load  && (offset == OFF_RX_DATA);

    // ------------------------------------------------------------------------
    // TX holding register: one byte, no queueing
    // ------------------------------------------------------------------------
    logic tx_free;
    assign tx_free = ~uart_tx_valid;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end else if (tx_store) begin
            uart_tx_data  <= cpu_wdata[7:0];
            uart_tx_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // RX buffer
    // ------------------------------------------------------------------------
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       rx_avail;
    logic       rx_push;
    logic       rx_pop;

    assign rx_avail      = ~rx_empty;
    assign uart_rx_ready = ~rx_full;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    // An empty buffer ignores the pop; the load then simply returns 0.
    assign rx_pop        = rx_pop_req && rx_avail;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  rx_mem [RX_FIFO_DEPTH];

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_head  = rx_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rx_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr[AW-1:0]] <= uart_rx_data;
    end
`else
    logic       rx_valid_q;
    logic [7:0] rx_byte;

    assign rx_empty = ~rx_valid_q;
    assign rx_full  = rx_valid_q;
    assign rx_head  = rx_byte;

    // Push is only possible when empty and pop only when full, so the two
    // never coincide in this single-entry form.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_q <= 1'b0;
            rx_byte    <= 8'h00;
        end else if (rx_push) begin
            rx_byte    <= uart_rx_data;
            rx_valid_q <= 1'b1;
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end

    logic unused_depth;
    assign unused_depth = RX_FIFO_DEPTH[0];
`endif

    // ------------------------------------------------------------------------
    // Performance counters; a clear store beats a same-cycle increment
    // ------------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else if (cnt_clear) begin
            cycle_cnt <= 32'd0;
            inst_cnt  <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'd0, inst_retired};
        end
    end

    // ------------------------------------------------------------------------
    // Read mux (pre-store state) and registered load data
    // ------------------------------------------------------------------------
    logic [31:0] rd_mux;

    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            OFF_STATUS:    rd_mux = {30'd0, rx_avail, tx_free};
            OFF_RX_DATA:   rd_mux = rx_avail ? {24'd0, rx_head} : 32'd0;
            OFF_CYCLE_CNT: rd_mux = cycle_cnt;
            OFF_INST_CNT:  rd_mux = inst_cnt;
            default:       rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= 32'd0;
        end else if (cpu_re) begin
            cpu_rdata <= load ? rd_mux : 32'd0;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[31:8];

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
`timescale 1ns/1ps
module tb_uart_mmio_ctrl;

`ifdef UART_RX_FIFO_EN
    localparam int RX_DEPTH = 8;
`else
    localparam int RX_DEPTH = 1;
`endif
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        inst_retired;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected load data queued at issue, compared when it appears.
    logic [31:0] exp_q  [$];
    string       name_q [$];
    // Model of the RX buffer contents.
    logic [7:0]  rx_model [$];
    logic        rd_due;

    uart_mmio_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_rdata     (cpu_rdata),
        .inst_retired  (inst_retired),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_due <= 1'b0;
        else      rd_due <= cpu_re;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        string       n;
        if (rd_due) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL load_unexpected: got %h, required no pending load", cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (cpu_rdata !== e) begin
                    failures++;
                    $display("FAIL %s: got %h, required %h", n, cpu_rdata, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Bus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------------
    task automatic issue_load(input logic [7:0] off, input logic [31:0] exp, input string nm);
        cpu_addr = BASE | {24'd0, off};
        cpu_re   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic do_load(input logic [7:0] off, input logic [31:0] exp, input string nm);
        issue_load(off, exp, nm);
        @(posedge clk);
        @(negedge clk);
        cpu_re = 1'b0;
    endtask

    task automatic issue_store(input logic [31:0] addr, input logic [31:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_we    = 4'hF;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        issue_store(addr, data);
        @(posedge clk);
        @(negedge clk);
        cpu_we = 4'h0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (uart_rx_ready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        uart_rx_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL rx_send_timeout: byte %h never accepted, required acceptance within 50 cycles", b);
        end else begin
            rx_model.push_back(b);
        end
    endtask

    task automatic pop_model(input string nm);
        logic [7:0] b;
        b = rx_model.pop_front();
        do_load(8'h04, {24'd0, b}, nm);
    endtask

    task automatic drain_rx;
        while (rx_model.size() > 0) pop_model("rx_drain");
        do_load(8'h04, 32'd0, "rx_empty_read");
        do_load(8'h00, 32'h1, "status_after_drain");
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_rdata, uart_tx_valid, uart_tx_data, uart_rx_ready} !== {32'd0, 1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: rdata=%h tx_valid=%b tx_data=%h rx_ready=%b, required 0/0/00/1",
                     cpu_rdata, uart_tx_valid, uart_tx_data, uart_rx_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        do_load(8'h00, 32'h1, "reset_status");
        do_load(8'h14, 32'h0, "reset_inst_cnt");
        do_load(8'h0C, 32'h0, "unmapped_read");
        // Load outside the window, and a store outside the window at the TX offset.
        cpu_addr = 32'h9000_0000; cpu_re = 1'b1;
        exp_q.push_back(32'd0); name_q.push_back("outside_window_read");
        @(posedge clk); @(negedge clk); cpu_re = 1'b0;
        do_store(32'h8000_0108, 32'h77);
        checks++;
        if (uart_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL outside_window_store: tx_valid=%b, required 0", uart_tx_valid);
        end
    endtask

    task automatic test_tx;
        uart_tx_ready = 1'b0;
        do_store(BASE | 32'h08, 32'hFFFF_FF41);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (uart_tx_valid !== (c <= 5) || uart_tx_data !== 8'h41) begin
                failures++;
                $display("FAIL tx_window_c%0d: valid=%b data=%h, required valid=%b data=41",
                         c, uart_tx_valid, uart_tx_data, (c <= 5));
            end
            case (c)
                0: issue_load(8'h00, 32'h0, "status_tx_busy");
                1: begin cpu_re = 1'b0; issue_store(BASE | 32'h08, 32'h42); end
                2: cpu_we = 4'h0;
                5: uart_tx_ready = 1'b1;
                6: uart_tx_ready = 1'b0;
                7: issue_load(8'h00, 32'h1, "status_tx_done");
                8: cpu_re = 1'b0;
                default: ;
            endcase
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_rx_order;
        logic [7:0] bytes [3] = '{8'h10, 8'h20, 8'h30};
        for (int i = 0; i < 3; i++) begin
            if (rx_model.size() == RX_DEPTH) pop_model("rx_order");
            send_byte(bytes[i]);
        end
        while (rx_model.size() > 0) pop_model("rx_order");
        do_load(8'h04, 32'd0, "rx_fourth_load");
        do_load(8'h00, 32'h1, "status_rx_empty");
    endtask

    task automatic test_rx_full;
        for (int i = 0; i < RX_DEPTH; i++) send_byte(8'hA0 + 8'(i));
        checks++;
        if (uart_rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rx_full_ready: got %b, required 0", uart_rx_ready);
        end
        do_load(8'h00, 32'h3, "status_rx_full");
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h99;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (uart_rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rx_held_off: ready=%b, required 0", uart_rx_ready);
        end
        pop_model("rx_full_pop");
        checks++;
        if (uart_rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_ready_reassert: got %b, required 1", uart_rx_ready);
        end
        rx_model.push_back(8'h99);
        @(posedge clk);
        @(negedge clk);
        uart_rx_valid = 1'b0;
        checks++;
        if (uart_rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rx_held_accepted: ready=%b, required 0 (buffer full again)", uart_rx_ready);
        end
        drain_rx();
    endtask

    task automatic test_counters;
        do_store(BASE | 32'h18, 32'h0);
        for (int i = 0; i < 20; i++) begin
            inst_retired = (i % 4 == 0);
            @(posedge clk);
            @(negedge clk);
        end
        inst_retired = 1'b0;
        do_load(8'h10, 32'd20, "cycle_cnt_20");
        do_load(8'h14, 32'd5, "inst_cnt_5");
        inst_retired = 1'b1;
        do_store(BASE | 32'h18, 32'h0);
        inst_retired = 1'b0;
        do_load(8'h10, 32'd0, "cycle_after_clear");
        do_load(8'h14, 32'd0, "inst_clear_wins");
    endtask

    task automatic test_wrap;
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        issue_load(8'h10, 32'hFFFF_FFFF, "cycle_max");
        @(posedge clk);
        @(negedge clk);
        issue_load(8'h10, 32'h0, "cycle_wrap");
        @(posedge clk);
        @(negedge clk);
        cpu_re = 1'b0;
    endtask

    task automatic test_mid_reset;
        send_byte(8'h5A);
        uart_tx_ready = 1'b0;
        do_store(BASE | 32'h08, 32'h55);
        checks++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h55) begin
            failures++;
            $display("FAIL mid_reset_pre: valid=%b data=%h, required 1/55", uart_tx_valid, uart_tx_data);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({uart_tx_valid, uart_tx_data, uart_rx_ready, cpu_rdata} !== {1'b0, 8'h00, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL mid_reset_async: valid=%b data=%h rx_ready=%b rdata=%h, required 0/00/1/0",
                     uart_tx_valid, uart_tx_data, uart_rx_ready, cpu_rdata);
        end
        rx_model.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_load(8'h00, 32'h1, "status_after_mid_reset");
        do_load(8'h04, 32'h0, "rx_discarded");
    endtask

    initial begin
        rst           = 1'b0;
        cpu_addr      = 32'd0;
        cpu_wdata     = 32'd0;
        cpu_we        = 4'h0;
        cpu_re        = 1'b0;
        inst_retired  = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        @(negedge clk);

        test_reset();
        test_tx();
        test_rx_order();
        test_rx_full();
        test_counters();
        test_wrap();
        test_mid_reset();

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL loads_outstanding: got %0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
